// File: rtl/progmem_arbiter.sv
// progmem_arbiter: two-master read arbiter in front of one program memory.
// m0 is the core fetch port and m1 is the debug/loader port.
//
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles before an error completion (2..255)
//   ARB_MODE        0 = round-robin, 1 = fixed priority to m0
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   m0_valid, m0_addr           m0 request, held until m0_ready
//   m0_ready, m0_rdata, m0_err  m0 one-cycle completion, data, error
//   m1_*                        same as m0_* for the debug port
//   s_valid, s_addr             request to program memory
//   s_ready, s_rdata            program memory response
//   busy                        high whenever the FSM is not IDLE
//   grant_id                    owner of current/most recent transfer
module progmem_arbiter #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ARB_MODE       = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        s_valid,
   output logic [31:0] s_addr,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Last WAIT cycle index; reaching it with no s_ready aborts.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CNT_MAX = 8'hFF;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        last_grant_q;
   logic        grant_q;
   logic        s_valid_q;
   logic [31:0] s_addr_q;
   logic        busy_q;
   logic        m0_ready_q;
   logic        m1_ready_q;
   logic [31:0] m0_rdata_q;
   logic [31:0] m1_rdata_q;
   logic        m0_err_q;
   logic        m1_err_q;

   logic        any_req_d;
   logic        winner_d;
   logic [31:0] win_addr_d;

   assign any_req_d = m0_valid | m1_valid;

   // A lone requester always wins. On a tie, round-robin picks
   // the master that did not own the previous transfer; last_grant
   // resets to 1 so m0 takes the first tie in either mode.
   always_comb begin
      winner_d = 1'b0;
      if (m0_valid && m1_valid) begin
         if (ARB_MODE == 1) begin
            winner_d = 1'b0;
         end else begin
            winner_d = ~last_grant_q;
         end
      end else if (m1_valid) begin
         winner_d = 1'b1;
      end
   end

   assign win_addr_d = winner_d ? m1_addr : m0_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         s_valid_q    <= 1'b0;
         s_addr_q     <= 32'd0;
         busy_q       <= 1'b0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_rdata_q   <= 32'd0;
         m1_rdata_q   <= 32'd0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
      end else begin
         // Ready is a pulse: only the WAIT exit raises it.
         m0_ready_q <= 1'b0;
         m1_ready_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  state_q      <= WAIT;
                  grant_q      <= winner_d;
                  last_grant_q <= winner_d;
                  s_addr_q     <= win_addr_d;
                  cnt_q        <= 8'd0;
                  s_valid_q    <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            WAIT: begin
               // s_ready wins over a timeout in the same cycle.
               if (s_ready) begin
                  state_q   <= RESP;
                  s_valid_q <= 1'b0;
                  if (grant_q) begin
                     m1_rdata_q <= s_rdata;
                     m1_err_q   <= 1'b0;
                     m1_ready_q <= 1'b1;
                  end else begin
                     m0_rdata_q <= s_rdata;
                     m0_err_q   <= 1'b0;
                     m0_ready_q <= 1'b1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_q   <= RESP;
                  s_valid_q <= 1'b0;
                  if (grant_q) begin
                     m1_rdata_q <= 32'd0;
                     m1_err_q   <= 1'b1;
                     m1_ready_q <= 1'b1;
                  end else begin
                     m0_rdata_q <= 32'd0;
                     m0_err_q   <= 1'b1;
                     m0_ready_q <= 1'b1;
                  end
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RESP: begin
               // Always drop back through IDLE so s_valid stays
               // low for RESP plus IDLE between transfers.
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               s_valid_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign m0_ready = m0_ready_q;
   assign m0_rdata = m0_rdata_q;
   assign m0_err   = m0_err_q;
   assign m1_ready = m1_ready_q;
   assign m1_rdata = m1_rdata_q;
   assign m1_err   = m1_err_q;
   assign s_valid  = s_valid_q;
   assign s_addr   = s_addr_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: directed bench for progmem_arbiter.
// Runs a round-robin and a fixed-priority instance on shared inputs.
module tb_progmem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_valid;
   logic [31:0] m0_addr;
   logic        m1_valid;
   logic [31:0] m1_addr;
   logic        s_ready;
   logic [31:0] s_rdata;

   logic        r_m0_ready, r_m0_err, r_m1_ready, r_m1_err;
   logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr;
   logic        r_s_valid, r_busy, r_grant;

   logic        f_m0_ready, f_m0_err, f_m1_ready, f_m1_err;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr;
   logic        f_s_valid, f_busy, f_grant;

   int passed;
   int total;

   progmem_arbiter #(.TIMEOUT_CYCLES(15), .ARB_MODE(0)) dut_rr (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_addr(m0_addr),
      .m0_ready(r_m0_ready), .m0_rdata(r_m0_rdata), .m0_err(r_m0_err),
      .m1_valid(m1_valid), .m1_addr(m1_addr),
      .m1_ready(r_m1_ready), .m1_rdata(r_m1_rdata), .m1_err(r_m1_err),
      .s_valid(r_s_valid), .s_addr(r_s_addr),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .busy(r_busy), .grant_id(r_grant)
   );

   progmem_arbiter #(.TIMEOUT_CYCLES(15), .ARB_MODE(1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_addr(m0_addr),
      .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
      .m1_valid(m1_valid), .m1_addr(m1_addr),
      .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
      .s_valid(f_s_valid), .s_addr(f_s_addr),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .busy(f_busy), .grant_id(f_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic nclk();
      @(negedge clk);
   endtask

   int rr_seq[$];
   int r0, r1, f0, f1, n_sv, gap, min_gap_r, min_gap_f, gap_f;
   logic seen_r, seen_f, got;

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b1;
      m0_valid = 1'b0; m0_addr = 32'd0;
      m1_valid = 1'b0; m1_addr = 32'd0;
      s_ready = 1'b0; s_rdata = 32'd0;
      nclk(); nclk();

      // Reset values.
      chk("rst_s_valid", {31'd0, r_s_valid}, 32'd0);
      chk("rst_busy", {31'd0, r_busy}, 32'd0);
      chk("rst_grant", {31'd0, r_grant}, 32'd0);
      chk("rst_s_addr", r_s_addr, 32'd0);
      chk("rst_ready", {30'd0, r_m0_ready, r_m1_ready}, 32'd0);
      rst = 1'b0;
      nclk();

      // Single read: ready on the 2nd WAIT cycle.
      m0_valid = 1'b1; m0_addr = 32'h8;
      nclk();
      chk("sr_s_valid_w1", {31'd0, r_s_valid}, 32'd1);
      chk("sr_s_addr_w1", r_s_addr, 32'h8);
      chk("sr_busy_w1", {31'd0, r_busy}, 32'd1);
      chk("sr_ready_w1", {31'd0, r_m0_ready}, 32'd0);
      nclk();
      chk("sr_s_addr_w2", r_s_addr, 32'h8);
      s_ready = 1'b1; s_rdata = 32'h02040737;
      nclk();
      chk("sr_m0_ready", {31'd0, r_m0_ready}, 32'd1);
      chk("sr_m0_rdata", r_m0_rdata, 32'h02040737);
      chk("sr_m0_err", {31'd0, r_m0_err}, 32'd0);
      chk("sr_m1_ready", {31'd0, r_m1_ready}, 32'd0);
      chk("sr_s_valid_resp", {31'd0, r_s_valid}, 32'd0);
      m0_valid = 1'b0; s_ready = 1'b0;
      nclk();
      chk("sr_ready_gone", {31'd0, r_m0_ready}, 32'd0);
      chk("sr_idle_busy", {31'd0, r_busy}, 32'd0);
      chk("sr_rdata_hold", r_m0_rdata, 32'h02040737);

      // Both masters continuously valid, s_ready stuck high.
      rst = 1'b1;
      nclk();
      rst = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h100;
      m1_valid = 1'b1; m1_addr = 32'h200;
      s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
      r0 = 0; r1 = 0; f0 = 0; f1 = 0;
      gap = 0; gap_f = 0; min_gap_r = 99; min_gap_f = 99;
      seen_r = 1'b0; seen_f = 1'b0;
      for (int i = 0; i < 12; i++) begin
         nclk();
         if (r_m0_ready) begin
            rr_seq.push_back(0); r0++;
            chk("rr_grant_m0", {31'd0, r_grant}, 32'd0);
         end
         if (r_m1_ready) begin
            rr_seq.push_back(1); r1++;
            chk("rr_grant_m1", {31'd0, r_grant}, 32'd1);
         end
         if (f_m0_ready) f0++;
         if (f_m1_ready) f1++;
         if (r_s_valid) begin
            if (seen_r && gap < min_gap_r) min_gap_r = gap;
            seen_r = 1'b1; gap = 0;
         end else begin
            gap++;
         end
         if (f_s_valid) begin
            if (seen_f && gap_f < min_gap_f) min_gap_f = gap_f;
            seen_f = 1'b1; gap_f = 0;
         end else begin
            gap_f++;
         end
      end
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
      chk("rr_pulses", rr_seq.size(), 4);
      for (int i = 0; i < rr_seq.size(); i++) begin
         chk($sformatf("rr_seq%0d", i), rr_seq[i], i % 2);
      end
      chk("rr_m0_cnt", r0, 2);
      chk("rr_m1_cnt", r1, 2);
      chk("rr_gap", min_gap_r, 2);
      chk("fp_m0_cnt", f0, 4);
      chk("fp_m1_cnt", f1, 0);
      chk("fp_gap", min_gap_f, 2);
      chk("fp_grant", {31'd0, f_grant}, 32'd0);
      nclk(); nclk();

      // Timeout on m1: s_ready never rises.
      m1_valid = 1'b1; m1_addr = 32'h300;
      n_sv = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         nclk();
         if (r_s_valid) begin
            n_sv++;
            chk("to_addr", r_s_addr, 32'h300);
         end
         if (r_m1_ready) got = 1'b1;
      end
      chk("to_done", {31'd0, got}, 32'd1);
      chk("to_sv_cycles", n_sv, 15);
      chk("to_err", {31'd0, r_m1_err}, 32'd1);
      chk("to_rdata", r_m1_rdata, 32'd0);
      chk("to_m0_ready", {31'd0, r_m0_ready}, 32'd0);
      chk("to_m0_hold", r_m0_rdata, 32'hDEADBEEF);
      m1_valid = 1'b0;
      nclk();
      chk("to_idle", {31'd0, r_busy}, 32'd0);
      nclk();

      // s_ready on the timeout cycle; m0 drops valid mid-WAIT.
      m0_valid = 1'b1; m0_addr = 32'h44;
      s_rdata = 32'hCAFE0001;
      got = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         nclk();
         if (r_m0_ready) got = 1'b1;
         if (i == 2) m0_valid = 1'b0;
         if (i == 15) s_ready = 1'b1;
      end
      chk("edge_early", {31'd0, got}, 32'd0);
      nclk();
      s_ready = 1'b0;
      chk("edge_ready", {31'd0, r_m0_ready}, 32'd1);
      chk("edge_err", {31'd0, r_m0_err}, 32'd0);
      chk("edge_rdata", r_m0_rdata, 32'hCAFE0001);
      nclk(); nclk();

      // Reset in the 1st WAIT cycle, then an m1 read.
      m0_valid = 1'b1; m0_addr = 32'h50;
      nclk();
      chk("mr_wait", {31'd0, r_s_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_s_valid", {31'd0, r_s_valid}, 32'd0);
      chk("mr_busy", {31'd0, r_busy}, 32'd0);
      chk("mr_rdata", r_m0_rdata, 32'd0);
      chk("mr_s_addr", r_s_addr, 32'd0);
      nclk();
      rst = 1'b0; m0_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nclk();
         if (r_m0_ready || r_m1_ready) got = 1'b1;
      end
      chk("mr_no_pulse", {31'd0, got}, 32'd0);
      m1_valid = 1'b1; m1_addr = 32'h60; s_rdata = 32'h12345678;
      nclk();
      nclk();
      s_ready = 1'b1;
      nclk();
      chk("mr_m1_ready", {31'd0, r_m1_ready}, 32'd1);
      chk("mr_m1_rdata", r_m1_rdata, 32'h12345678);
      chk("mr_grant", {31'd0, r_grant}, 32'd1);
      m1_valid = 1'b0; s_ready = 1'b0;
      nclk();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
